// File: rtl/sdram_port_pkg.sv
// Shared types and default sizing for the SDRAM Avalon-MM request bridge.
package sdram_port_pkg;

    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_TIMEOUT = 256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } sdram_port_state_t;

endpackage

// File: rtl/sdram_port_timeout_counter.sv
// Clear/enable counter that flags the cycle in which it reaches LIMIT.
module timeout_counter #(
    parameter int LIMIT = 256,
    localparam int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturates at LIMIT rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_W'(LIMIT))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted in the enabled cycle that brings the count up to LIMIT.
    assign tc_o = en_i && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/sdram_port.sv
// Single-request bridge from the control unit to an Avalon-MM SDRAM slave,
// with a read-latency timeout guarding against a hung slave.
module sdram_port
    import sdram_port_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              data_read,
    output logic              write_done,
    output logic              busy,
    output logic              timeout_err,
    output logic              protocol_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest
);

    sdram_port_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              op_read_q, op_read_d;
    logic              timeout_q, timeout_d;
    logic              perr_q, perr_d;
    logic              wait_tc;

    timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_rd_timeout (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (state_q == ST_RD_REQ),
        .en_i    (state_q == ST_RD_WAIT),
        .tc_o    (wait_tc)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        op_read_d = op_read_q;
        timeout_d = timeout_q;
        perr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (read_en) begin
                    // A simultaneous write is dropped; the read wins.
                    addr_d    = addr;
                    op_read_d = 1'b1;
                    timeout_d = 1'b0;
                    perr_d    = write_en;
                    state_d   = ST_RD_REQ;
                end else if (write_en) begin
                    addr_d    = addr;
                    wdata_d   = wdata;
                    op_read_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        rdata_d = avm_readdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    rdata_d = avm_readdata;
                    state_d = ST_DONE;
                end else if (wait_tc) begin
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WR_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && (read_en || write_en)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            op_read_q <= 1'b0;
            timeout_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            op_read_q <= op_read_d;
            timeout_q <= timeout_d;
            perr_q    <= perr_d;
        end
    end

    // Completion pulses last exactly the single DONE cycle.
    assign data_read     = (state_q == ST_DONE) && op_read_q;
    assign write_done    = (state_q == ST_DONE) && !op_read_q;
    assign timeout_err   = (state_q == ST_DONE) && timeout_q;
    assign protocol_err  = perr_q;
    assign busy          = (state_q != ST_IDLE);
    assign rdata         = rdata_q;
    assign avm_read      = (state_q == ST_RD_REQ);
    assign avm_write     = (state_q == ST_WR_REQ);
    assign avm_address   = addr_q;
    assign avm_writedata = wdata_q;

endmodule
